// File: rtl/pipe_shifter_pkg.sv
// Shared types and helpers for the pipelined barrel shifter: shift opcode
// encoding and the pipeline-depth calculation used by the top and the bench.
package shift_pkg;

    typedef enum logic [1:0] {
        OP_LSL = 2'b00,
        OP_LSR = 2'b01,
        OP_ASR = 2'b10,
        OP_ROR = 2'b11
    } shift_op_t;

    // Number of register stages: one per group of lps mux levels, last group may be short.
    function automatic int stage_count(input int width, input int lps);
        int shamt_w;
        shamt_w = $clog2(width);
        return (shamt_w + lps - 1) / lps;
    endfunction

endpackage

// File: rtl/pipe_shifter_if.sv
// Operand/result handshake bundle for pipe_shifter. The master side presents
// operands and consumes results; the slave side is the shifter itself.
interface pipe_shifter_if
    import shift_pkg::*;
#(
    parameter int WIDTH = 64
);
    localparam int SHAMT_W = $clog2(WIDTH);

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    shift_op_t          in_op;

    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_zero;

    modport master (
        output in_valid, in_data, in_shamt, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_zero
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_op, out_ready,
        output in_ready, out_valid, out_data, out_zero
    );

endinterface

// File: rtl/pipe_shifter_stage.sv
// One pipeline slice of the barrel shifter: NUM_LEVELS mux levels starting at
// FIRST_LEVEL, then a register that holds its contents while downstream stalls.
module shift_stage
    import shift_pkg::*;
#(
    parameter  int WIDTH       = 64,
    parameter  int FIRST_LEVEL = 0,
    parameter  int NUM_LEVELS  = 1,
    localparam int SHAMT_W     = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               reset,

    input  logic               valid_i,
    output logic               ready_o,
    input  logic [WIDTH-1:0]   data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  shift_op_t          op_i,
    input  logic               fill_i,

    output logic               valid_o,
    input  logic               ready_i,
    output logic [WIDTH-1:0]   data_o,
    output logic [SHAMT_W-1:0] shamt_o,
    output shift_op_t          op_o,
    output logic               fill_o,
    output logic               zero_o
);

    logic               valid_q;
    logic [WIDTH-1:0]   data_q;
    logic [SHAMT_W-1:0] shamt_q;
    shift_op_t          op_q;
    logic               fill_q;
    logic               zero_q;

    logic [WIDTH-1:0]   data_d;
    logic               zero_d;
    logic               load_en;

    // Shift by 2^lvl; ASR takes its fill from the sign captured at the input.
    function automatic logic [WIDTH-1:0] shift_level(
        input logic [WIDTH-1:0] d,
        input shift_op_t        op,
        input logic             fill,
        input int               lvl
    );
        logic [WIDTH-1:0] ones;
        int               amt;
        ones = '1;
        amt  = 1 << lvl;
        case (op)
            OP_LSL:  return d << amt;
            OP_LSR:  return d >> amt;
            OP_ASR:  return (d >> amt) | (fill ? ~(ones >> amt) : '0);
            OP_ROR:  return (d >> amt) | (d << (WIDTH - amt));
            default: return d;
        endcase
    endfunction

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        data_d = data_i;
        for (int k = 0; k < NUM_LEVELS; k++) begin
            if (shamt_i[FIRST_LEVEL + k]) begin
                data_d = shift_level(data_d, op_i, fill_i, FIRST_LEVEL + k);
            end
        end
        zero_d = (data_d == '0);
    end

    assign ready_o = !valid_q || ready_i;
    assign load_en = ready_o && valid_i;

    // NOTE: state uses non-blocking assignments so all stages update from pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the datapath is reset as well, so the result port reads zero after reset.
            valid_q <= 1'b0;
            data_q  <= '0;
            shamt_q <= '0;
            op_q    <= OP_LSL;
            fill_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else if (ready_o) begin
            valid_q <= valid_i;
            if (load_en) begin
                data_q  <= data_d;
                shamt_q <= shamt_i;
                op_q    <= op_i;
                fill_q  <= fill_i;
                zero_q  <= zero_d;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign shamt_o = shamt_q;
    assign op_o    = op_q;
    assign fill_o  = fill_q;
    assign zero_o  = zero_q;

endmodule

// File: rtl/pipe_shifter.sv
// Pipelined LSL/LSR/ASR/ROR barrel shifter: cascaded log2 mux levels split into
// register stages, with a valid/ready chain so the consumer can stall it losslessly.
module pipe_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH            = 64,
    parameter int LEVELS_PER_STAGE = 2
) (
    input logic           clock,
    input logic           reset,
    pipe_shifter_if.slave bus
);

    localparam int SHAMT_W    = $clog2(WIDTH);
    localparam int NUM_STAGES = stage_count(WIDTH, LEVELS_PER_STAGE);

    if (WIDTH < 8 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("pipe_shifter: WIDTH must be a power of two and at least 8");
    end
    if (LEVELS_PER_STAGE < 1 || LEVELS_PER_STAGE > SHAMT_W) begin : g_bad_lps
        $error("pipe_shifter: LEVELS_PER_STAGE must lie in 1..SHAMT_W");
    end

    // Index i is the input side of stage i; index NUM_STAGES is the result port.
    logic               valid_w [NUM_STAGES+1];
    logic               ready_w [NUM_STAGES+1];
    logic [WIDTH-1:0]   data_w  [NUM_STAGES+1];
    logic [SHAMT_W-1:0] shamt_w [NUM_STAGES+1];
    shift_op_t          op_w    [NUM_STAGES+1];
    logic               fill_w  [NUM_STAGES+1];
    logic               zero_w  [NUM_STAGES];

    assign valid_w[0] = bus.in_valid;
    assign data_w[0]  = bus.in_data;
    assign shamt_w[0] = bus.in_shamt;
    assign op_w[0]    = bus.in_op;
    assign fill_w[0]  = bus.in_data[WIDTH-1];
    assign bus.in_ready = ready_w[0];

    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
        localparam int FIRST = i * LEVELS_PER_STAGE;
        localparam int NUM   = (SHAMT_W - FIRST < LEVELS_PER_STAGE) ? SHAMT_W - FIRST
                                                                    : LEVELS_PER_STAGE;
        shift_stage #(
            .WIDTH      (WIDTH),
            .FIRST_LEVEL(FIRST),
            .NUM_LEVELS (NUM)
        ) u_stage (
            .clock  (clock),
            .reset  (reset),
            .valid_i(valid_w[i]),
            .ready_o(ready_w[i]),
            .data_i (data_w[i]),
            .shamt_i(shamt_w[i]),
            .op_i   (op_w[i]),
            .fill_i (fill_w[i]),
            .valid_o(valid_w[i+1]),
            .ready_i(ready_w[i+1]),
            .data_o (data_w[i+1]),
            .shamt_o(shamt_w[i+1]),
            .op_o   (op_w[i+1]),
            .fill_o (fill_w[i+1]),
            .zero_o (zero_w[i])
        );
    end

    // Only the final stage's zero flag matches the visible result.
    assign ready_w[NUM_STAGES] = bus.out_ready;
    assign bus.out_valid       = valid_w[NUM_STAGES];
    assign bus.out_data        = data_w[NUM_STAGES];
    assign bus.out_zero        = zero_w[NUM_STAGES-1];

endmodule
